if_fetch_buffer: RTL and testbench

- Instruction-fetch consumer of the PC: takes the word address produced by the PC, reads instruction memory, buffers returned words in order, and presents split fields back to the control and PC logic.
- Fields presented: opcode, funct low bits, immediate, jump target.
- Decouples a multi-cycle instruction memory from the datapath.
- Supports flush on branch/jump redirect.

---
 rtl/if_fetch_buffer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_if_fetch_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buffer.sv
// -----------------------------------------------------------------------------
// if_fetch_buffer
// Fetch stage that consumes the PC's word address. It issues reads to a
// multi-cycle instruction memory and pairs each in-order response with its
// address through a tag FIFO. The returned {instr, pc} pairs are kept in order
// in a circular buffer. The head entry is presented to the datapath together
// with its decoded fields. On a redirect, everything older is discarded. Any
// responses still outstanding at that point are counted in drop and swallowed
// in FLUSH.
//
// Parameters:
//   DEPTH : buffer entries (power of 2, >= 2); also caps buffered + in-flight
//   AW    : word address width
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pc, pc_valid, pc_ready    fetch request handshake (combinational issue)
//   redirect                  branch/jump taken, flush older work
//   mem_req, mem_addr         memory read strobe/address
//   mem_rdata, mem_rvalid     in-order memory response
//   instr_valid, instr_ready  head handshake toward the consumer
//   instr, instr_pc           head word and the address it came from
//   Control, jr,
//   immediate_data, jumpAdd   slices [31:26], [3:0], [15:0], [25:0] of instr
//
// Build option:
//   IFB_BYPASS_EN : when defined, a response that arrives while the buffer is
//                   empty is presented on instr the same cycle.
// -----------------------------------------------------------------------------

// Flags a response that arrives while no request is outstanding or pending drop.
module if_fetch_buffer_chk #(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          mem_rvalid,
  input logic [CW-1:0] inflight_i,
  input logic [CW-1:0] drop_i
);
  // A response with nothing outstanding means the memory broke the protocol.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid && (inflight_i == {CW{1'b0}}) && (drop_i == {CW{1'b0}})))
    else $error("if_fetch_buffer: response received with nothing outstanding");
endmodule

module if_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          redirect,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_rvalid,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [AW-1:0] instr_pc,
  output logic [5:0]    Control,
  output logic [3:0]    jr,
  output logic [15:0]   immediate_data,
  output logic [25:0]   jumpAdd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW:0]   CAP      = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] tag_head_q, tag_head_d, tag_tail_q, tag_tail_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0]   buf_instr_q [DEPTH];
  logic [AW-1:0] buf_pc_q    [DEPTH];
  logic [AW-1:0] tag_q       [DEPTH];

  logic          flushing_s, credit_s, accept_s, buf_empty_s;
  logic          resp_ok_s, bypass_s, push_s, pop_s;
  logic [CW-1:0] drop_sum_s;

  assign flushing_s  = (state_q == S_FLUSH);
  assign credit_s    = (({1'b0, count_q} + {1'b0, inflight_q}) < CAP);
  // Reset gating keeps the handshake quiet while rst is held, even when empty.
  assign pc_ready    = !rst && !flushing_s && credit_s && !redirect;
  assign accept_s    = pc_valid && pc_ready;
  assign mem_req     = accept_s;
  assign mem_addr    = accept_s ? pc : {AW{1'b0}};
  assign buf_empty_s = (count_q == CNT_ZERO);
  // Responses are kept only outside FLUSH, away from a redirect, and when owed.
  assign resp_ok_s   = mem_rvalid && !flushing_s && !redirect && (inflight_q != CNT_ZERO);
`ifdef IFB_BYPASS_EN
  assign bypass_s    = !rst && resp_ok_s && buf_empty_s;
`else
  assign bypass_s    = 1'b0;
`endif
  // A bypassed word taken by the consumer the same cycle is never stored.
  assign push_s      = resp_ok_s && !(bypass_s && instr_ready);
  assign pop_s       = !buf_empty_s && instr_ready;
  // Redirect drop total: only one of these is non-zero (inflight is 0 in FLUSH).
  assign drop_sum_s  = drop_q + inflight_q;

  assign instr_valid    = !buf_empty_s || bypass_s;
  assign Control        = instr[31:26];
  assign jr             = instr[3:0];
  assign immediate_data = instr[15:0];
  assign jumpAdd        = instr[25:0];

  // Head presentation: buffered entry first, then the optional bypass, else zeros.
  always_comb begin
    instr    = 32'h0;
    instr_pc = {AW{1'b0}};
    if (!buf_empty_s) begin
      instr    = buf_instr_q[head_q];
      instr_pc = buf_pc_q[head_q];
    end else if (bypass_s) begin
      instr    = mem_rdata;
      instr_pc = tag_q[tag_head_q];
    end else begin
      instr    = 32'h0;
      instr_pc = {AW{1'b0}};
    end
  end

  // Next-state logic for the FSM, pointers, and credit/drop counters.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    tag_head_d = tag_head_q;
    tag_tail_d = tag_tail_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (redirect) begin
      head_d     = PTR_ZERO;
      tail_d     = PTR_ZERO;
      count_d    = CNT_ZERO;
      tag_head_d = PTR_ZERO;
      tag_tail_d = PTR_ZERO;
      inflight_d = CNT_ZERO;
      // A response arriving with the redirect is one fewer to swallow later.
      if (mem_rvalid && (drop_sum_s != CNT_ZERO)) begin
        drop_d = drop_sum_s - CNT_ONE;
      end else begin
        drop_d = drop_sum_s;
      end
      if (drop_d == CNT_ZERO) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_FLUSH;
      end
    end else begin
      case (state_q)
        S_FLUSH: begin
          if (mem_rvalid && (drop_q != CNT_ZERO)) begin
            drop_d = drop_q - CNT_ONE;
          end else begin
            drop_d = drop_q;
          end
          if (drop_d == CNT_ZERO) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FLUSH;
          end
        end
        S_IDLE, S_FETCH: begin
          if (pop_s) begin
            head_d = head_q + PTR_ONE;
          end else begin
            head_d = head_q;
          end
          if (push_s) begin
            tail_d = tail_q + PTR_ONE;
          end else begin
            tail_d = tail_q;
          end
          if (push_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
          end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_ONE;
          end else begin
            count_d = count_q;
          end
          if (accept_s) begin
            tag_tail_d = tag_tail_q + PTR_ONE;
          end else begin
            tag_tail_d = tag_tail_q;
          end
          if (resp_ok_s) begin
            tag_head_d = tag_head_q + PTR_ONE;
          end else begin
            tag_head_d = tag_head_q;
          end
          if (accept_s && !resp_ok_s) begin
            inflight_d = inflight_q + CNT_ONE;
          end else if (resp_ok_s && !accept_s) begin
            inflight_d = inflight_q - CNT_ONE;
          end else begin
            inflight_d = inflight_q;
          end
          if (inflight_d != CNT_ZERO) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, pointer and counter registers; reset empties everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      head_q     <= PTR_ZERO;
      tail_q     <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      tag_head_q <= PTR_ZERO;
      tag_tail_q <= PTR_ZERO;
      inflight_q <= CNT_ZERO;
      drop_q     <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      tag_head_q <= tag_head_d;
      tag_tail_q <= tag_tail_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Entry storage: validity lives in count/inflight, so the data needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      buf_instr_q[tail_q] <= mem_rdata;
      buf_pc_q[tail_q]    <= tag_q[tag_head_q];
    end
    if (accept_s) begin
      tag_q[tag_tail_q] <= pc;
    end
  end

  if_fetch_buffer_chk #(.CW(CW)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .mem_rvalid (mem_rvalid),
    .inflight_i (inflight_q),
    .drop_i     (drop_q)
  );

endmodule

// File: tb/tb_if_fetch_buffer.sv
module tb_if_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          pc_valid, pc_ready, redirect, mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          mem_rvalid, instr_valid, instr_ready;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic [5:0]    Control;
  logic [3:0]    jr;
  logic [15:0]   immediate_data;
  logic [25:0]   jumpAdd;

  always #5 clk = ~clk;

  if_fetch_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .redirect(redirect), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .Control(Control), .jr(jr), .immediate_data(immediate_data), .jumpAdd(jumpAdd)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: ordered buffer contents, outstanding tags, drop count.
  logic [31:0]   mb_word[$];
  logic [AW-1:0] mb_pc[$];
  logic [AW-1:0] mtag[$];
  int            mdrop = 0;
  bit            mflush = 1'b0;

  // Memory environment: in-order pending requests with due cycles.
  logic [AW-1:0] mq_addr[$];
  int            mq_due[$];
  int            last_due = 0;
  int            cyc = 0;
  int            lat = 1;

  // Observations of the most recent cycle and everything delivered.
  bit            o_pc_ready, o_instr_valid, o_mem_req, o_rvalid;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   dl_word[$];
  logic [AW-1:0] dl_pc[$];
  logic [5:0]    dl_ctl[$];
  logic [25:0]   dl_jmp[$];

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    case (a)
      32'd0:   mem_word = 32'h20080005;
      32'd1:   mem_word = 32'h08000010;
      32'd2:   mem_word = 32'h2009000A;
      32'd3:   mem_word = 32'h01095020;
      default: mem_word = (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit pv, input logic [AW-1:0] p, input bit rd, input bit rdy);
    pc_valid    = pv;
    pc = p;
    redirect    = rd;
    instr_ready = rdy;
  endtask

  task automatic clear_dl();
    dl_word.delete(); dl_pc.delete(); dl_ctl.delete(); dl_jmp.delete();
  endtask

  // One clock: memory answers, outputs are checked at negedge, model advances.
  task automatic cycle();
    bit            e_ready, e_acc, resp_ok, byp, e_valid;
    logic [31:0]   e_word;
    logic [AW-1:0] e_pc, t;
    int            occ, infl, total, due;
    if (rst) begin
      mq_addr.delete(); mq_due.delete(); last_due = cyc;
    end
    if (!rst && mq_due.size() > 0 && mq_due[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    @(negedge clk);
    occ     = mb_word.size();
    infl    = mtag.size();
    e_ready = !rst && !mflush && (occ + infl < DEPTH) && !redirect;
    e_acc   = pc_valid && e_ready;
    resp_ok = !rst && mem_rvalid && !mflush && !redirect && (infl > 0);
    byp     = 1'b0;
`ifdef IFB_BYPASS_EN
    byp     = resp_ok && (occ == 0);
`endif
    if (rst) begin
      e_valid = 1'b0; e_word = 32'h0; e_pc = '0;
    end else if (occ > 0) begin
      e_valid = 1'b1; e_word = mb_word[0]; e_pc = mb_pc[0];
    end else if (byp) begin
      e_valid = 1'b1; e_word = mem_rdata; e_pc = mtag[0];
    end else begin
      e_valid = 1'b0; e_word = 32'h0; e_pc = '0;
    end
    chk("pc_ready", 64'(pc_ready), 64'(e_ready));
    chk("mem_req", 64'(mem_req), 64'(e_acc));
    if (e_acc) chk("mem_addr", 64'(mem_addr), 64'(pc));
    chk("instr_valid", 64'(instr_valid), 64'(e_valid));
    chk("instr", 64'(instr), 64'(e_word));
    chk("instr_pc", 64'(instr_pc), 64'(e_pc));
    chk("Control", 64'(Control), 64'(e_word[31:26]));
    chk("jr", 64'(jr), 64'(e_word[3:0]));
    chk("immediate_data", 64'(immediate_data), 64'(e_word[15:0]));
    chk("jumpAdd", 64'(jumpAdd), 64'(e_word[25:0]));
    o_pc_ready = pc_ready; o_instr_valid = instr_valid; o_mem_req = mem_req;
    o_mem_addr = mem_addr; o_rvalid = mem_rvalid;
    if (instr_valid && instr_ready) begin
      dl_word.push_back(instr); dl_pc.push_back(instr_pc);
      dl_ctl.push_back(Control); dl_jmp.push_back(jumpAdd);
    end
    if (mem_req) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      mq_addr.push_back(mem_addr); mq_due.push_back(due);
      last_due = due;
    end
    if (rst) begin
      mb_word.delete(); mb_pc.delete(); mtag.delete(); mdrop = 0; mflush = 1'b0;
    end else if (redirect) begin
      total = mdrop + infl;
      mdrop = (mem_rvalid && total > 0) ? total - 1 : total;
      mb_word.delete(); mb_pc.delete(); mtag.delete();
      mflush = (mdrop > 0);
    end else if (mflush) begin
      if (mem_rvalid && mdrop > 0) mdrop--;
      mflush = (mdrop > 0);
    end else begin
      if (occ > 0 && instr_ready) begin
        void'(mb_word.pop_front()); void'(mb_pc.pop_front());
      end
      if (resp_ok) begin
        t = mtag.pop_front();
        if (!(byp && instr_ready)) begin
          mb_word.push_back(mem_rdata); mb_pc.push_back(t);
        end
      end
      if (e_acc) mtag.push_back(pc);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 60 && !done; k++) begin
      cycle();
      done = (mb_word.size() == 0 && mtag.size() == 0 && !mflush && mq_due.size() == 0);
    end
    chk("drain_done", 64'(done), 64'd1);
  endtask

  initial begin
    logic [31:0]   stream_exp [4];
    logic [AW-1:0] p, first_pc;
    int            acc, nf, bad, nrv;
    bit            got;
    stream_exp = '{32'h20080005, 32'h08000010, 32'h2009000A, 32'h01095020};
    rst = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    drive(1'b1, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    repeat (2) cycle();
    rst = 1'b0;

    // Streaming, latency 2, consumer always ready.
    lat = 2; clear_dl();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), 1'b0, 1'b1);
      cycle();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    repeat (6) cycle();
    chk("stream_count", 64'(dl_word.size()), 64'd4);
    for (int i = 0; i < 4 && i < dl_word.size(); i++) begin
      chk("stream_word", 64'(dl_word[i]), 64'(stream_exp[i]));
      chk("stream_pc", 64'(dl_pc[i]), 64'(i));
    end
    if (dl_word.size() >= 2) begin
      chk("stream_ctl0", 64'(dl_ctl[0]), 64'(6'h08));
      chk("stream_jmp1", 64'(dl_jmp[1]), 64'(26'h0000010));
    end

    // Full backpressure, pop restores credit, then wrap the pointers.
    drain(); lat = 1; clear_dl(); acc = 0; p = 32'h100;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, p, 1'b0, 1'b0);
      cycle();
      if (o_pc_ready) begin acc++; p++; end
    end
    chk("bp_accepts", 64'(acc), 64'd4);
    chk("bp_ready_low", 64'(o_pc_ready), 64'd0);
    drive(1'b0, p, 1'b0, 1'b1);
    cycle();
    drive(1'b1, p, 1'b0, 1'b0);
    cycle();
    chk("bp_ready_back", 64'(o_pc_ready), 64'd1);
    if (o_pc_ready) begin acc++; p++; end
    nf = 0;
    for (int k = 0; k < 200 && nf < 10; k++) begin
      drive(1'b1, p, 1'b0, 1'($urandom_range(0, 1)));
      cycle();
      if (o_pc_ready) begin nf++; p++; end
    end
    drain();
    chk("wrap_fetches", 64'(nf), 64'd10);
    chk("wrap_delivered", 64'(dl_word.size()), 64'(acc + nf));
    bad = 0;
    for (int i = 0; i < dl_word.size(); i++) begin
      if (dl_pc[i] !== 32'h100 + 32'(i)) bad++;
      if (dl_word[i] !== mem_word(32'h100 + 32'(i))) bad++;
    end
    chk("wrap_order", 64'(bad), 64'd0);

    // Redirect with three requests in flight.
    drain(); lat = 6; clear_dl();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 1'b0, 1'b1);
      cycle();
    end
    drive(1'b1, 32'h99, 1'b1, 1'b1);
    cycle();
    chk("rd_ready_low", 64'(o_pc_ready), 64'd0);
    chk("rd_no_req", 64'(o_mem_req), 64'd0);
    nrv = 0; got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      drive(1'b1, 32'h40, 1'b0, 1'b1);
      cycle();
      if (o_pc_ready) got = 1'b1;
      else if (o_rvalid) nrv++;
    end
    chk("rd_accept", 64'(got), 64'd1);
    chk("rd_discarded", 64'(nrv), 64'd3);
    drain();
    first_pc = (dl_pc.size() > 0) ? dl_pc[0] : 32'hFFFF_FFFF;
    chk("rd_dl_count", 64'(dl_pc.size()), 64'd1);
    chk("rd_first_pc", 64'(first_pc), 64'h40);

    // Redirect coincident with the only response.
    drain(); lat = 2; clear_dl();
    drive(1'b1, 32'h20, 1'b0, 1'b1); cycle();
    drive(1'b0, '0, 1'b0, 1'b1);     cycle();
    drive(1'b0, '0, 1'b1, 1'b1);     cycle();
    chk("co_ready_low", 64'(o_pc_ready), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b1);     cycle();
    chk("co_idle_ready", 64'(o_pc_ready), 64'd1);
    repeat (3) cycle();
    chk("co_nodeliver", 64'(dl_word.size()), 64'd0);

    // Response-to-instr_valid latency on an empty buffer.
    drain(); lat = 1; clear_dl();
    drive(1'b1, 32'h30, 1'b0, 1'b1); cycle();
    drive(1'b0, '0, 1'b0, 1'b1);     cycle();
`ifdef IFB_BYPASS_EN
    chk("lat_same", 64'(o_instr_valid), 64'd1);
`else
    chk("lat_same", 64'(o_instr_valid), 64'd0);
`endif
    cycle();
`ifdef IFB_BYPASS_EN
    chk("lat_next", 64'(o_instr_valid), 64'd0);
`else
    chk("lat_next", 64'(o_instr_valid), 64'd1);
`endif
    chk("lat_dl", 64'(dl_word.size()), 64'd1);

    // Reset mid-operation with two buffered and two in flight.
    drain(); lat = 1;
    drive(1'b1, 32'h50, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h51, 1'b0, 1'b0); cycle();
    lat = 5;
    drive(1'b1, 32'h52, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h53, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h54, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_ready", 64'(pc_ready), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    cycle();
    rst = 1'b0; lat = 1; clear_dl();
    drive(1'b1, 32'h0, 1'b0, 1'b1);
    cycle();
    chk("post_rst_req", 64'(o_mem_req), 64'd1);
    chk("post_rst_addr", 64'(o_mem_addr), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b1);
    repeat (3) cycle();
    chk("post_rst_dl", 64'(dl_word.size()), 64'd1);
    if (dl_word.size() > 0) chk("post_rst_word", 64'(dl_word[0]), 64'h20080005);

    // Randomized traffic against the model.
    drain();
    for (int k = 0; k < 700; k++) begin
      lat = int'($urandom_range(1, 4));
      drive(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 63)),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
